// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file for the decode stage.
//
// Holds 2**ADDR_WIDTH registers of DATA_WIDTH bits plus one busy bit per
// register used by decode to detect RAW hazards on in-flight producers.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   raddr / rdata     NUM_RD combinational read ports (packed, port i at
//                     [i*ADDR_WIDTH +: ADDR_WIDTH] / [i*DATA_WIDTH +: DATA_WIDTH])
//   rbusy             stored busy bit of each read address (never bypassed)
//   wen0..wdata0      write port 0 (writeback stage), byte strobes
//   wen1..wdata1      write port 1 (load / long-latency return), byte strobes;
//                     port 1 wins per byte when both hit the same register
//   alloc_en/addr     marks a register busy when decode issues to it
//   busy_cnt          registered population count of the busy bits
module reg_file_mp #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr,
    output logic [NUM_RD*DATA_WIDTH-1:0] rdata,
    output logic [NUM_RD-1:0]            rbusy,
    input  logic                         wen0,
    input  logic [ADDR_WIDTH-1:0]        waddr0,
    input  logic [DATA_WIDTH/8-1:0]      wstrb0,
    input  logic [DATA_WIDTH-1:0]        wdata0,
    input  logic                         wen1,
    input  logic [ADDR_WIDTH-1:0]        waddr1,
    input  logic [DATA_WIDTH/8-1:0]      wstrb1,
    input  logic [DATA_WIDTH-1:0]        wdata1,
    input  logic                         alloc_en,
    input  logic [ADDR_WIDTH-1:0]        alloc_addr,
    output logic [ADDR_WIDTH:0]          busy_cnt
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam int NB    = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];
    logic [DEPTH-1:0]      busy_q;
    logic [DEPTH-1:0]      busy_d;
    logic [ADDR_WIDTH:0]   busy_cnt_q;
    logic [ADDR_WIDTH:0]   busy_cnt_d;

    logic wr0_ok;
    logic wr1_ok;
    logic alloc_ok;

    // Register 0 is hard-wired when ZERO_REG is set: writes and
    // allocations aimed at it are dropped before they reach any state.
    assign wr0_ok   = wen0 && !((ZERO_REG != 0) && (waddr0 == '0));
    assign wr1_ok   = wen1 && !((ZERO_REG != 0) && (waddr1 == '0));
    assign alloc_ok = alloc_en && !((ZERO_REG != 0) && (alloc_addr == '0));

    // Next-state storage and busy vector. Port 1 is applied after port 0
    // so it wins on overlapping bytes; allocation is applied after the
    // clearing writes so a new producer wins over a retiring one.
    always_comb begin
        mem_d      = mem_q;
        busy_d     = busy_q;
        busy_cnt_d = '0;
        for (int b = 0; b < NB; b++) begin
            if (wr0_ok && wstrb0[b]) begin
                mem_d[waddr0][b*8 +: 8] = wdata0[b*8 +: 8];
            end
        end
        for (int b = 0; b < NB; b++) begin
            if (wr1_ok && wstrb1[b]) begin
                mem_d[waddr1][b*8 +: 8] = wdata1[b*8 +: 8];
            end
        end
        if (wr0_ok && (|wstrb0)) begin
            busy_d[waddr0] = 1'b0;
        end
        if (wr1_ok && (|wstrb1)) begin
            busy_d[waddr1] = 1'b0;
        end
        if (alloc_ok) begin
            busy_d[alloc_addr] = 1'b1;
        end
        // Counting the next-state vector keeps busy_cnt aligned with busy_q.
        for (int j = 0; j < DEPTH; j++) begin
            busy_cnt_d = busy_cnt_d + {{ADDR_WIDTH{1'b0}}, busy_d[j]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
            busy_q     <= '0;
            busy_cnt_q <= '0;
        end else begin
            mem_q      <= mem_d;
            busy_q     <= busy_d;
            busy_cnt_q <= busy_cnt_d;
        end
    end

    // Read ports. With BYPASS the next-state value already merges both
    // write ports over the stored word per byte, so it is the forwarded data.
    always_comb begin
        rdata = '0;
        rbusy = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            rbusy[i] = busy_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            if ((ZERO_REG != 0) && (raddr[i*ADDR_WIDTH +: ADDR_WIDTH] == '0)) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = '0;
            end else if (BYPASS != 0) begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_d[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            end else begin
                rdata[i*DATA_WIDTH +: DATA_WIDTH] = mem_q[raddr[i*ADDR_WIDTH +: ADDR_WIDTH]];
            end
        end
    end

    assign busy_cnt = busy_cnt_q;

endmodule

// File: tb/tb_reg_file_mp.sv
// tb_reg_file_mp: bench for reg_file_mp. Two instances share all inputs:
// u_dut (BYPASS=1) and u_nb (BYPASS=0). A word-level model of the register
// file and busy set predicts every output each cycle; directed vectors add
// hand-computed literal expectations.
module tb_reg_file_mp;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [NR*AW-1:0] raddr;
    logic [NR*DW-1:0] rdata, rdata_nb;
    logic [NR-1:0]    rbusy, rbusy_nb;
    logic             wen0, wen1, alloc_en;
    logic [AW-1:0]    waddr0, waddr1, alloc_addr;
    logic [3:0]       wstrb0, wstrb1;
    logic [DW-1:0]    wdata0, wdata1;
    logic [AW:0]      busy_cnt, busy_cnt_nb;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    reg_file_mp #(.BYPASS(1)) u_dut (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata), .rbusy(rbusy),
        .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_cnt)
    );

    reg_file_mp #(.BYPASS(0)) u_nb (
        .clk(clk), .rst_n(rst_n), .raddr(raddr), .rdata(rdata_nb), .rbusy(rbusy_nb),
        .wen0(wen0), .waddr0(waddr0), .wstrb0(wstrb0), .wdata0(wdata0),
        .wen1(wen1), .waddr1(waddr1), .wstrb1(wstrb1), .wdata1(wdata1),
        .alloc_en(alloc_en), .alloc_addr(alloc_addr), .busy_cnt(busy_cnt_nb)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit check_en = 1'b0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Literal check against the oldest hand-computed value in exp_q.
    task automatic lit(input string name, input logic [31:0] act);
        logic [31:0] e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: expected queue empty", name);
        end else begin
            e = exp_q.pop_front();
            chk(name, act, e);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
    endtask

    function automatic logic [31:0] strb_mask(input logic [3:0] s);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) if (s[b]) m = m | (32'hFF << (8 * b));
        return m;
    endfunction

    // Word the register at a holds once this cycle's writes land.
    function automatic logic [31:0] post_write(input int a);
        logic [31:0] v;
        v = m_mem[a];
        if (a != 0 && wen0 && int'(waddr0) == a)
            v = (v & ~strb_mask(wstrb0)) | (wdata0 & strb_mask(wstrb0));
        if (a != 0 && wen1 && int'(waddr1) == a)
            v = (v & ~strb_mask(wstrb1)) | (wdata1 & strb_mask(wstrb1));
        return v;
    endfunction

    function automatic logic [31:0] exp_read(input int a, input bit byp);
        if (a == 0) return '0;
        return byp ? post_write(a) : m_mem[a];
    endfunction

    function automatic int m_count();
        int c;
        c = 0;
        for (int k = 0; k < DEPTH; k++) c += int'(m_busy[k]);
        return c;
    endfunction

    always @(negedge rst_n) model_clear();

    always @(posedge clk) begin
        logic [31:0] n0, n1;
        if (rst_n) begin
            n0 = post_write(int'(waddr0));
            n1 = post_write(int'(waddr1));
            if (wen0 && waddr0 != 0) m_mem[waddr0] = n0;
            if (wen1 && waddr1 != 0) m_mem[waddr1] = n1;
            if (wen0 && (|wstrb0) && waddr0 != 0) m_busy[waddr0] = 1'b0;
            if (wen1 && (|wstrb1) && waddr1 != 0) m_busy[waddr1] = 1'b0;
            if (alloc_en && alloc_addr != 0) m_busy[alloc_addr] = 1'b1;
        end
    end

    // Every-cycle compare, on the falling edge.
    always @(negedge clk) begin
        int a;
        if (check_en) begin
            for (int i = 0; i < NR; i++) begin
                a = int'(raddr[i*AW +: AW]);
                chk($sformatf("rdata_byp[%0d]", i), rdata[i*DW +: DW], exp_read(a, 1'b1));
                chk($sformatf("rdata_nobyp[%0d]", i), rdata_nb[i*DW +: DW], exp_read(a, 1'b0));
                chk($sformatf("rbusy[%0d]", i), 32'(rbusy[i]), 32'(m_busy[a]));
                chk($sformatf("rbusy_nb[%0d]", i), 32'(rbusy_nb[i]), 32'(m_busy[a]));
            end
            chk("busy_cnt", 32'(busy_cnt), 32'(m_count()));
            chk("busy_cnt_nb", 32'(busy_cnt_nb), 32'(m_count()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen0 = 1'b0; waddr0 = '0; wstrb0 = '0; wdata0 = '0;
        wen1 = 1'b0; waddr1 = '0; wstrb1 = '0; wdata1 = '0;
        alloc_en = 1'b0; alloc_addr = '0;
        raddr = '0;
    endtask

    task automatic wr0(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wen0 = 1'b1; waddr0 = a; wstrb0 = s; wdata0 = d;
    endtask

    task automatic wr1(input logic [4:0] a, input logic [3:0] s, input logic [31:0] d);
        wen1 = 1'b1; waddr1 = a; wstrb1 = s; wdata1 = d;
    endtask

    task automatic alloc(input logic [4:0] a);
        alloc_en = 1'b1; alloc_addr = a;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        model_clear();
        rst_n = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        check_en = 1'b1;

        // load some state, then reset in the middle of a cycle with a write pending
        next_cycle(); idle(); wr0(5'd1, 4'hF, 32'hCAFE0001); wr1(5'd2, 4'hF, 32'hCAFE0002); alloc(5'd4);
        next_cycle(); idle(); wr0(5'd3, 4'hF, 32'hCAFE0003); alloc(5'd6); rd(5'd1, 5'd2);
        next_cycle(); idle(); wr0(5'd8, 4'hF, 32'h55555555); alloc(5'd10); rd(5'd3, 5'd4);
        #2 rst_n = 1'b0;
        next_cycle(); idle();
        next_cycle(); rst_n = 1'b1;

        for (int a = 0; a < DEPTH; a++) begin
            next_cycle(); idle(); rd(5'(a), 5'(31 - a));
            #3;
            exp_q.push_back(32'h0); lit("reset_rd0", rdata[31:0]);
            exp_q.push_back(32'h0); lit("reset_rd1", rdata[63:32]);
            exp_q.push_back(32'h0); lit("reset_rbusy", 32'(rbusy));
        end
        exp_q.push_back(32'h0); lit("reset_busy_cnt", 32'(busy_cnt));

        // byte strobes
        next_cycle(); idle(); wr0(5'd5, 4'hF, 32'hAABBCCDD);
        next_cycle(); idle(); wr0(5'd5, 4'b0101, 32'h11223344);
        next_cycle(); idle(); rd(5'd5, 5'd5);
        #3;
        exp_q.push_back(32'hAA22CC44); lit("strobe_r5", rdata[31:0]);
        exp_q.push_back(32'hAA22CC44); lit("strobe_r5_nb", rdata_nb[63:32]);

        // dual-write collision
        next_cycle(); idle(); wr0(5'd7, 4'hF, 32'h00000000); wr1(5'd7, 4'b0011, 32'hFFFFFFFF);
        next_cycle(); idle(); rd(5'd7, 5'd0);
        #3;
        exp_q.push_back(32'h0000FFFF); lit("collide_r7", rdata[31:0]);
        exp_q.push_back(32'h0000FFFF); lit("collide_r7_nb", rdata_nb[31:0]);

        // same-cycle bypass
        next_cycle(); idle(); wr0(5'd3, 4'hF, 32'h12345678); rd(5'd3, 5'd0);
        #3;
        exp_q.push_back(32'h12345678); lit("bypass_same", rdata[31:0]);
        exp_q.push_back(32'h00000000); lit("nobypass_old", rdata_nb[31:0]);
        next_cycle(); idle(); rd(5'd3, 5'd0);
        #3;
        exp_q.push_back(32'h12345678); lit("nobypass_new", rdata_nb[31:0]);

        // zero register
        next_cycle(); idle(); wr0(5'd0, 4'hF, 32'hDEADBEEF); alloc(5'd0); rd(5'd0, 5'd0);
        #3;
        exp_q.push_back(32'h0); lit("zero_bypass", rdata[31:0]);
        next_cycle(); idle(); rd(5'd0, 5'd0);
        #3;
        exp_q.push_back(32'h0); lit("zero_rd", rdata[31:0]);
        exp_q.push_back(32'h0); lit("zero_rbusy", 32'(rbusy[0]));
        exp_q.push_back(32'h0); lit("zero_busy_cnt", 32'(busy_cnt));

        // scoreboard on r9
        next_cycle(); idle(); alloc(5'd9); rd(5'd9, 5'd9);
        #3;
        exp_q.push_back(32'h0); lit("sb_alloc_same", 32'(rbusy[0]));
        next_cycle(); idle(); rd(5'd9, 5'd9);
        #3;
        exp_q.push_back(32'h1); lit("sb_alloc_busy", 32'(rbusy[0]));
        exp_q.push_back(32'h1); lit("sb_alloc_cnt", 32'(busy_cnt));
        next_cycle(); idle(); alloc(5'd9); rd(5'd9, 5'd9);
        next_cycle(); idle(); rd(5'd9, 5'd9);
        #3;
        exp_q.push_back(32'h1); lit("sb_realloc_cnt", 32'(busy_cnt));
        next_cycle(); idle(); wr0(5'd9, 4'hF, 32'h99999999); alloc(5'd9); rd(5'd9, 5'd9);
        next_cycle(); idle(); rd(5'd9, 5'd9);
        #3;
        exp_q.push_back(32'h1); lit("sb_wr_alloc_busy", 32'(rbusy[0]));
        exp_q.push_back(32'h1); lit("sb_wr_alloc_cnt", 32'(busy_cnt));
        next_cycle(); idle(); wr1(5'd9, 4'b0001, 32'h000000AA); rd(5'd9, 5'd9);
        #3;
        exp_q.push_back(32'h1); lit("sb_rbusy_not_bypassed", 32'(rbusy[1]));
        exp_q.push_back(32'h999999AA); lit("sb_wr_data_bypass", rdata[31:0]);
        next_cycle(); idle(); rd(5'd9, 5'd9);
        #3;
        exp_q.push_back(32'h0); lit("sb_clear_busy", 32'(rbusy[0]));
        exp_q.push_back(32'h0); lit("sb_clear_cnt", 32'(busy_cnt));

        // mixed traffic, checked by the model every cycle
        for (int n = 0; n < 60; n++) begin
            next_cycle(); idle();
            if ($urandom_range(0, 1) == 1) wr0(5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 2) == 0) wr1(5'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom);
            if ($urandom_range(0, 1) == 1) alloc(5'($urandom_range(0, 15)));
            rd(5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
        end

        next_cycle(); idle();
        repeat (2) next_cycle();
        // ---------------- report ----------------
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the pipelined CPU datapath: NUM_RD asynchronous read ports, two write ports with per-byte strobes, optional write-to-read bypass, and a per-register busy scoreboard for hazard detection.
- Sits in the decode stage.
- Write ports are fed by the writeback stage (port 0) and the load/long-latency return path (port 1).
- The allocate port is driven when decode issues an instruction with a destination register.

Parameters:
- DATA_WIDTH, 32, register width in bits; must be a multiple of 8.
- ADDR_WIDTH, 5, address width; depth = 2**ADDR_WIDTH.
- NUM_RD, 2, number of read ports, 1..4.
- ZERO_REG, 1, when 1 register 0 reads as 0, ignores writes and is never busy.
- BYPASS, 1, when 1 a same-cycle write is forwarded combinationally to matching read ports.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst_n, input, 1, asynchronous active-low reset.
- raddr, input, NUM_RD*ADDR_WIDTH, read addresses; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata, output, NUM_RD*DATA_WIDTH, read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- rbusy, output, NUM_RD, busy bit of each read address.
- wen0, input, 1, write enable, port 0.
- waddr0, input, ADDR_WIDTH, write address, port 0.
- wstrb0, input, DATA_WIDTH/8, byte strobes, port 0.
- wdata0, input, DATA_WIDTH, write data, port 0.
- wen1, input, 1, write enable, port 1.
- waddr1, input, ADDR_WIDTH, write address, port 1.
- wstrb1, input, DATA_WIDTH/8, byte strobes, port 1.
- wdata1, input, DATA_WIDTH, write data, port 1.
- alloc_en, input, 1, mark a register busy.
- alloc_addr, input, ADDR_WIDTH, register to mark busy.
- busy_cnt, output, ADDR_WIDTH+1, number of registers currently busy.

Behaviour:
- Reset:
  - Clock is clk; reset is rst_n, asynchronous, active-low.
  - While rst_n=0, all registers clear to 0, all busy bits clear, busy_cnt=0.
  - Read ports then return 0 (or forwarded data if BYPASS=1 and a write is presented) with rbusy=0.
  - Reset asserted mid-operation discards any write or allocation in flight that cycle.
  - Deassertion takes effect at the next rising edge.
- Writes:
  - On the rising edge, when wenK=1, each byte b with wstrbK[b]=1 is updated from wdataK; bytes with strobe 0 are unchanged.
  - Both ports write the same address in one cycle: per byte, port 1 wins where wstrb1[b]=1; port 0 bytes not covered by port 1 are still written.
  - ZERO_REG=1 and waddrK=0: the write is ignored.
- Reads:
  - Combinational; latency 0 from raddr to rdata.
  - ZERO_REG=1 and raddr=0: rdata=0, regardless of BYPASS.
  - BYPASS=1: for each byte, the read data is the value the register will hold after this edge's writes (port 1 over port 0 over stored value). Read-after-write in the same cycle therefore sees new data.
  - BYPASS=0: reads return the stored value; new data is visible the cycle after the edge.
- Scoreboard:
  - Each register has a busy bit.
  - A write on either port with any strobe bit set clears the busy bit of its address at the edge.
  - alloc_en=1 sets the busy bit of alloc_addr at the edge.
  - Allocation and write to the same address in the same cycle: the busy bit ends at 1 (the new producer wins).
  - Allocating an already-busy register leaves it busy; busy_cnt does not double count.
  - ZERO_REG=1: alloc_addr=0 is ignored.
  - rbusy[i] reflects the stored busy bit; it is not bypassed, and with BYPASS=1 a same-cycle clearing write still shows rbusy=1.
- busy_cnt:
  - Registered; equals the population count of the busy bits after each edge.
  - Computed from the next-state busy vector, so there is no cycle lag relative to the busy bits.
  - Range 0..2**ADDR_WIDTH.
- No internal state machine beyond the storage and busy bits.
- All outputs are defined for every input combination; there are no X sources after reset.

Test Plan:
- Reset then read: assert rst_n=0 mid-run with registers loaded; release and read all 32 addresses -> every rdata=0, rbusy=0, busy_cnt=0.
- Byte strobes: write 0xAABBCCDD to r5 with wstrb0=4'hF, then write 0x11223344 with wstrb0=4'b0101 -> r5 reads 0xAA22CC44.
- Dual-write collision: port 0 writes r7=0x00000000 with strobes F and port 1 writes r7=0xFFFFFFFF with strobes 4'b0011 in the same cycle -> r7 reads 0x0000FFFF.
- Bypass: BYPASS=1, write r3=0x12345678 with raddr[0]=3 in the same cycle -> rdata[0]=0x12345678 in that cycle. BYPASS=0 build -> old value in that cycle, new value the next cycle.
- Zero register: write r0=0xDEADBEEF and alloc r0 -> rdata=0, rbusy=0, busy_cnt unchanged.
- Scoreboard:
  - Alloc r9 -> rbusy=1 and busy_cnt=1 the next cycle.
  - Alloc r9 again -> busy_cnt stays 1.
  - Write r9 with alloc r9 in the same cycle -> still busy.
  - Write r9 alone -> rbusy=0 and busy_cnt=0.
